// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one Avalon memory master between instruction fetch
// and the load/store stage. One request at a time; a 1-cycle done pulse returns
// completion (and read data) to the port that was served.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   if_req/if_addr             fetch request (held until if_done)
//   if_done/if_rdata           fetch completion pulse and fetched word
//   d_read/d_write/d_addr      data request (held until d_done)
//   d_wdata/d_byteenable       store data and byte lanes
//   d_done/d_rdata             data completion pulse and load data
//   avm_*                      Avalon master (address/read/write/writedata/
//                              byteenable out; waitrequest/readdata in)
//   bus_err                    sticky flag: a waitrequest stall timed out
//
// Configuration
//   ARB_ROUND_ROBIN_EN  defined: ties alternate against last_grant.
//                       undefined: data always wins a tie.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic                bus_err
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LIM = (TIMEOUT > 1) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic {FETCH = 1'b0, DATA = 1'b1} port_t;

  state_t            state, state_n;
  port_t             gnt, gnt_n;
`ifdef ARB_ROUND_ROBIN_EN
  port_t             last_grant, last_grant_n;
`endif
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_n;
  logic [ADDR_W-1:0] avm_address_n;
  logic              avm_read_n, avm_write_n;
  logic [DATA_W-1:0] avm_writedata_n;
  logic [BE_W-1:0]   avm_byteenable_n;
  logic              if_done_n, d_done_n, bus_err_n;
  logic              resp_rd, resp_rd_n, resp_to, resp_to_n;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_q_n, d_rdata_q, d_rdata_q_n;
  logic [DATA_W-1:0] resp_val;
  logic              want_f, want_d, pick_d, accept, time_out;

  // Read data arrives the cycle after accept, i.e. in the done cycle, so it is
  // forwarded straight through while done is high and held in a register after.
  assign resp_val = resp_to ? '0 : avm_readdata;
  assign if_rdata = if_done ? resp_val : if_rdata_q;
  assign d_rdata  = (d_done && (resp_rd || resp_to)) ? resp_val : d_rdata_q;

  // Next-state and next-output logic
  always_comb begin
    state_n          = state;
    gnt_n            = gnt;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_n     = last_grant;
`endif
    wait_cnt_n       = wait_cnt;
    avm_address_n    = avm_address;
    avm_read_n       = avm_read;
    avm_write_n      = avm_write;
    avm_writedata_n  = avm_writedata;
    avm_byteenable_n = avm_byteenable;
    if_done_n        = 1'b0;
    d_done_n         = 1'b0;
    bus_err_n        = bus_err;
    resp_rd_n        = resp_rd;
    resp_to_n        = resp_to;
    if_rdata_q_n     = if_rdata_q;
    d_rdata_q_n      = d_rdata_q;

    accept   = (avm_read | avm_write) & ~avm_waitrequest;
    time_out = (TIMEOUT > 0) && avm_waitrequest && (wait_cnt == CNT_W'(TO_LIM));

    // The port whose done is pulsing this cycle may not win again yet.
    want_f = if_req & ~(state == RESP && gnt == FETCH);
    want_d = (d_read | d_write) & ~(state == RESP && gnt == DATA);
`ifdef ARB_ROUND_ROBIN_EN
    pick_d = want_d & (~want_f | (last_grant == FETCH));
`else
    pick_d = want_d;
`endif

    if (if_done) if_rdata_q_n = resp_val;
    if (d_done && (resp_rd || resp_to)) d_rdata_q_n = resp_val;

    case (state)
      IDLE, RESP: begin
        state_n = IDLE;
        if (want_f || want_d) begin
          state_n    = ISSUE;
          gnt_n      = pick_d ? DATA : FETCH;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_n = gnt_n;
`endif
          wait_cnt_n = '0;
          if (pick_d) begin
            avm_address_n    = d_addr;
            avm_writedata_n  = d_wdata;
            avm_byteenable_n = d_byteenable;
            avm_read_n       = d_read;
            avm_write_n      = d_write & ~d_read;
          end else begin
            avm_address_n    = if_addr;
            avm_writedata_n  = '0;
            avm_byteenable_n = '1;
            avm_read_n       = 1'b1;
            avm_write_n      = 1'b0;
          end
        end
      end
      ISSUE: begin
        if (accept || time_out) begin
          state_n     = RESP;
          avm_read_n  = 1'b0;
          avm_write_n = 1'b0;
          if_done_n   = (gnt == FETCH);
          d_done_n    = (gnt == DATA);
          resp_rd_n   = avm_read;
          resp_to_n   = time_out;
          if (time_out) bus_err_n = 1'b1;
        end else if (avm_waitrequest) begin
          wait_cnt_n = wait_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      gnt            <= FETCH;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant     <= FETCH;
`endif
      wait_cnt       <= '0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      if_done        <= 1'b0;
      d_done         <= 1'b0;
      bus_err        <= 1'b0;
      resp_rd        <= 1'b0;
      resp_to        <= 1'b0;
      if_rdata_q     <= '0;
      d_rdata_q      <= '0;
    end else begin
      state          <= state_n;
      gnt            <= gnt_n;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant     <= last_grant_n;
`endif
      wait_cnt       <= wait_cnt_n;
      avm_address    <= avm_address_n;
      avm_read       <= avm_read_n;
      avm_write      <= avm_write_n;
      avm_writedata  <= avm_writedata_n;
      avm_byteenable <= avm_byteenable_n;
      if_done        <= if_done_n;
      d_done         <= d_done_n;
      bus_err        <= bus_err_n;
      resp_rd        <= resp_rd_n;
      resp_to        <= resp_to_n;
      if_rdata_q     <= if_rdata_q_n;
      d_rdata_q      <= d_rdata_q_n;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction model.
module tb_mem_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_read, d_write;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_byteenable;
  logic        d_done;
  logic [31:0] d_rdata;
  logic [31:0] avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        bus_err;

  int vectors;
  int miscompares;
  bit chk_en;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_done(d_done), .d_rdata(d_rdata),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // Tracks the one outstanding bus access, who owns it, how long it has
  // stalled, and what each port should see when it completes.
  logic        e_if_done, e_d_done, e_rd_en, e_wr_en, e_bus_err;
  logic [31:0] e_addr, e_wdata, e_if_hold, e_d_hold;
  logic [3:0]  e_be;
  bit          e_zero, e_rd, own_data;
  int          stalls;
`ifdef ARB_ROUND_ROBIN_EN
  bit          last_data;
`endif

  always @(posedge clk) begin
    bit served_f, served_d, wf, wd, pick;
    if (reset) begin
      e_if_done = 0; e_d_done = 0; e_rd_en = 0; e_wr_en = 0; e_bus_err = 0;
      e_addr = 0; e_wdata = 0; e_be = 0; e_if_hold = 0; e_d_hold = 0;
      e_zero = 0; e_rd = 0; own_data = 0; stalls = 0;
`ifdef ARB_ROUND_ROBIN_EN
      last_data = 0;
`endif
    end else begin
      // Completion seen during the ending cycle becomes the held value.
      if (e_if_done) e_if_hold = e_zero ? 32'h0 : avm_readdata;
      if (e_d_done && (e_rd || e_zero)) e_d_hold = e_zero ? 32'h0 : avm_readdata;
      served_f = e_if_done;
      served_d = e_d_done;
      e_if_done = 0;
      e_d_done = 0;
      if (e_rd_en || e_wr_en) begin
        if (!avm_waitrequest || (stalls + 1 == TO)) begin
          e_zero = avm_waitrequest;
          if (avm_waitrequest) e_bus_err = 1;
          e_rd = e_rd_en;
          if (own_data) e_d_done = 1; else e_if_done = 1;
          e_rd_en = 0;
          e_wr_en = 0;
        end else begin
          stalls++;
        end
      end else begin
        wf = if_req && !served_f;
        wd = (d_read || d_write) && !served_d;
        if (wf || wd) begin
`ifdef ARB_ROUND_ROBIN_EN
          pick = wd && (!wf || !last_data);
          last_data = pick;
`else
          pick = wd;
`endif
          own_data = pick;
          stalls = 0;
          if (pick) begin
            e_addr = d_addr; e_wdata = d_wdata; e_be = d_byteenable;
            e_rd_en = d_read; e_wr_en = d_write && !d_read;
          end else begin
            e_addr = if_addr; e_wdata = 0; e_be = 4'hF;
            e_rd_en = 1; e_wr_en = 0;
          end
        end
      end
    end
  end

  // Per-cycle compare of every DUT output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("if_done", 64'(if_done), 64'(e_if_done));
      chk("d_done", 64'(d_done), 64'(e_d_done));
      chk("avm_read", 64'(avm_read), 64'(e_rd_en));
      chk("avm_write", 64'(avm_write), 64'(e_wr_en));
      chk("avm_address", 64'(avm_address), 64'(e_addr));
      chk("avm_writedata", 64'(avm_writedata), 64'(e_wdata));
      chk("avm_byteenable", 64'(avm_byteenable), 64'(e_be));
      chk("bus_err", 64'(bus_err), 64'(e_bus_err));
      chk("if_rdata", 64'(if_rdata),
          64'(e_if_done ? (e_zero ? 32'h0 : avm_readdata) : e_if_hold));
      chk("d_rdata", 64'(d_rdata),
          64'((e_d_done && (e_rd || e_zero)) ? (e_zero ? 32'h0 : avm_readdata) : e_d_hold));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  int stuck;
  int dop;

  initial begin
    vectors = 0; miscompares = 0; chk_en = 0;
    reset = 1; if_req = 0; if_addr = 0; d_read = 0; d_write = 0;
    d_addr = 0; d_wdata = 0; d_byteenable = 0;
    avm_waitrequest = 0; avm_readdata = 0;
    tick(); tick();
    chk_en = 1;
    neg();
    chk("rst_avm_read", 64'(avm_read), 64'd0);
    chk("rst_avm_address", 64'(avm_address), 64'd0);
    chk("rst_if_done", 64'(if_done), 64'd0);
    chk("rst_bus_err", 64'(bus_err), 64'd0);

    // fetch, no wait
    tick(); reset = 0; if_req = 1; if_addr = 32'hBFC00000;
    avm_readdata = 32'h3C011234; avm_waitrequest = 0;
    neg(); chk("t1_c0_read", 64'(avm_read), 64'd0);
    tick(); neg();
    chk("t1_c1_read", 64'(avm_read), 64'd1);
    chk("t1_c1_addr", 64'(avm_address), 64'hBFC00000);
    chk("t1_c1_be", 64'(avm_byteenable), 64'hF);
    tick(); if_req = 0; neg();
    chk("t1_c2_done", 64'(if_done), 64'd1);
    chk("t1_c2_rdata", 64'(if_rdata), 64'h3C011234);
    tick(); avm_readdata = 32'h0; neg();
    chk("t1_c3_hold", 64'(if_rdata), 64'h3C011234);

    // write with 3 wait cycles
    tick(); d_write = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    d_byteenable = 4'b0011; avm_waitrequest = 1;
    tick(); neg();
    chk("t2_c1_write", 64'(avm_write), 64'd1);
    chk("t2_c1_wdata", 64'(avm_writedata), 64'hDEADBEEF);
    chk("t2_c1_be", 64'(avm_byteenable), 64'h3);
    tick(); tick(); tick(); avm_waitrequest = 0; neg();
    chk("t2_c4_write", 64'(avm_write), 64'd1);
    tick(); d_write = 0; neg();
    chk("t2_c5_done", 64'(d_done), 64'd1);
    chk("t2_c5_ifdone", 64'(if_done), 64'd0);
    chk("t2_c5_write", 64'(avm_write), 64'd0);
    tick();

    // simultaneous fetch and load: load first, fetch straight from response
    tick(); if_req = 1; if_addr = 32'h400; d_read = 1; d_addr = 32'h200;
    d_byteenable = 4'hF; avm_readdata = 32'h11111111;
    tick(); neg();
    chk("t3_c1_addr", 64'(avm_address), 64'h200);
    tick(); d_read = 0; neg();
    chk("t3_c2_ddone", 64'(d_done), 64'd1);
    chk("t3_c2_drdata", 64'(d_rdata), 64'h11111111);
    chk("t3_c2_ifdone", 64'(if_done), 64'd0);
    tick(); avm_readdata = 32'h22222222; neg();
    chk("t3_c3_read", 64'(avm_read), 64'd1);
    chk("t3_c3_addr", 64'(avm_address), 64'h400);
    tick(); if_req = 0; neg();
    chk("t3_c4_ifdone", 64'(if_done), 64'd1);
    chk("t3_c4_ifrdata", 64'(if_rdata), 64'h22222222);
    chk("t3_c4_dhold", 64'(d_rdata), 64'h11111111);
    tick();

    // read and write together
    tick(); d_read = 1; d_write = 1; d_addr = 32'h300;
    tick(); neg();
    chk("t6_c1_read", 64'(avm_read), 64'd1);
    chk("t6_c1_write", 64'(avm_write), 64'd0);
    tick(); d_read = 0; d_write = 0; neg();
    chk("t6_c2_done", 64'(d_done), 64'd1);
    tick(); neg();
    chk("t6_c3_once", 64'(d_done), 64'd0);

    // timeout on a fetch
    tick(); if_req = 1; if_addr = 32'h500; avm_waitrequest = 1;
    tick(); tick(); tick(); tick(); neg();
    chk("t4_c4_read", 64'(avm_read), 64'd1);
    tick(); if_req = 0; avm_waitrequest = 0; neg();
    chk("t4_c5_read", 64'(avm_read), 64'd0);
    chk("t4_c5_done", 64'(if_done), 64'd1);
    chk("t4_c5_rdata", 64'(if_rdata), 64'd0);
    chk("t4_c5_err", 64'(bus_err), 64'd1);
    tick(); neg();
    chk("t4_c6_sticky", 64'(bus_err), 64'd1);

    // reset during a stalled issue
    tick(); if_req = 1; if_addr = 32'h600; avm_waitrequest = 1;
    tick();
    tick(); reset = 1;
    tick(); reset = 0; avm_waitrequest = 0; avm_readdata = 32'h33333333; neg();
    chk("t5_c3_read", 64'(avm_read), 64'd0);
    chk("t5_c3_done", 64'(if_done), 64'd0);
    chk("t5_c3_err", 64'(bus_err), 64'd0);
    chk("t5_c3_rdata", 64'(if_rdata), 64'd0);
    tick(); neg();
    chk("t5_c4_read", 64'(avm_read), 64'd1);
    chk("t5_c4_addr", 64'(avm_address), 64'h600);
    tick(); if_req = 0; neg();
    chk("t5_c5_done", 64'(if_done), 64'd1);
    chk("t5_c5_rdata", 64'(if_rdata), 64'h33333333);

    // randomized traffic
    stuck = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      reset = ($urandom_range(0, 399) == 0);
      avm_readdata = $urandom;
      if (stuck > 0) begin
        avm_waitrequest = 1;
        stuck--;
      end else begin
        avm_waitrequest = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 59) == 0) stuck = 6;
      end
      if (!if_req || e_if_done) begin
        if_req = ($urandom_range(0, 2) == 0) || (if_req && $urandom_range(0, 1) == 0);
        if_addr = $urandom;
      end
      if (!(d_read || d_write) || e_d_done) begin
        d_read = 0; d_write = 0;
        if ($urandom_range(0, 2) == 0) begin
          dop = $urandom_range(0, 7);
          d_read = (dop < 4) || (dop == 7);
          d_write = (dop >= 4);
        end
        d_addr = $urandom;
        d_wdata = $urandom;
        d_byteenable = 4'($urandom);
      end
    end
    tick();
    reset = 1; if_req = 0; d_read = 0; d_write = 0;
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
